div16_8_seq: RTL and testbench



---
 rtl/div16_8_seq.sv | 125 ++++++++++++
 tb/tb_div16_8_seq.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/div16_8_seq.sv
// Sequential radix-2 restoring divider: 16-bit unsigned dividend by 8-bit unsigned divisor.
// Optional approximation skips the k lowest quotient bits, so latency is 16-k cycles.
module div16_8_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [15:0] dat_in_a,
    input  logic [7:0]  dat_in_b,
    input  logic [3:0]  mask,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [15:0] dat_o,
    output logic [15:0] rem_o,
    output logic        div0_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t      state_reg, state_next;
    logic [4:0]  cnt_reg;
    logic [15:0] shift_reg;
    logic [15:0] keep_reg;
    logic [15:0] quo_reg;
    logic [7:0]  div_reg;
    logic [3:0]  k_reg;
    logic [8:0]  part_reg;
    logic [15:0] dat_reg, rem_reg;
    logic        div0_reg;

    logic        accept;
    logic        last_iter;
    logic [8:0]  part_shift;
    logic        ge;
    logic [8:0]  part_new;
    logic [15:0] quo_new;
    logic [15:0] low_mask;
    logic [15:0] dat_final;
    logic [15:0] rem_final;

    assign accept    = valid_i && (state_reg == IDLE);
    assign last_iter = (state_reg == CALC) && (cnt_reg == 5'd1);

    // part_reg always stays below the divisor, so the 9-bit shift never loses a bit.
    assign part_shift = (part_reg << 1) | {8'b0, shift_reg[15]};
    assign ge         = (part_shift >= {1'b0, div_reg});
    assign part_new   = ge ? (part_shift - {1'b0, div_reg}) : part_shift;
    assign quo_new    = (quo_reg << 1) | {15'b0, ge};

    // Skipped dividend bits fall straight through into the residual.
    assign low_mask  = ~(16'hFFFF << k_reg);
    assign dat_final = quo_new << k_reg;
    assign rem_final = ({7'b0, part_new} << k_reg) | (keep_reg & low_mask);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (valid_i) begin
                    state_next = (dat_in_b == 8'd0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (cnt_reg == 5'd1) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (ready_i) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 5'd0;
            shift_reg <= 16'd0;
            keep_reg  <= 16'd0;
            quo_reg   <= 16'd0;
            div_reg   <= 8'd0;
            k_reg     <= 4'd0;
            part_reg  <= 9'd0;
            dat_reg   <= 16'd0;
            rem_reg   <= 16'd0;
            div0_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                shift_reg <= dat_in_a;
                keep_reg  <= dat_in_a;
                div_reg   <= dat_in_b;
                k_reg     <= mask;
                quo_reg   <= 16'd0;
                part_reg  <= 9'd0;
                cnt_reg   <= 5'd16 - {1'b0, mask};
                if (dat_in_b == 8'd0) begin
                    dat_reg  <= 16'hFFFF;
                    rem_reg  <= dat_in_a;
                    div0_reg <= 1'b1;
                end
            end else if (state_reg == CALC) begin
                shift_reg <= shift_reg << 1;
                part_reg  <= part_new;
                quo_reg   <= quo_new;
                cnt_reg   <= cnt_reg - 5'd1;
                if (last_iter) begin
                    dat_reg  <= dat_final;
                    rem_reg  <= rem_final;
                    div0_reg <= 1'b0;
                end
            end
        end
    end

    assign ready_o = (state_reg == IDLE);
    assign valid_o = (state_reg == DONE);
    assign dat_o   = dat_reg;
    assign rem_o   = rem_reg;
    assign div0_o  = div0_reg;

endmodule

// File: tb/tb_div16_8_seq.sv
// Directed bench for div16_8_seq: expected results are queued at issue and
// compared against the DUT when valid_o appears.
module tb_div16_8_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] dat_in_a;
    logic [7:0]  dat_in_b;
    logic [3:0]  mask;
    logic        valid_o;
    logic        ready_i;
    logic [15:0] dat_o;
    logic [15:0] rem_o;
    logic        div0_o;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] dat;
        logic [15:0] rem;
        logic        div0;
        int          lat;
    } exp_t;

    exp_t sb[$];

    div16_8_seq dut (
        .clk      (clk),
        .rst      (rst),
        .valid_i  (valid_i),
        .ready_o  (ready_o),
        .dat_in_a (dat_in_a),
        .dat_in_b (dat_in_b),
        .mask     (mask),
        .valid_o  (valid_o),
        .ready_i  (ready_i),
        .dat_o    (dat_o),
        .rem_o    (rem_o),
        .div0_o   (div0_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Reference model written directly from the result definition.
    function automatic exp_t model(input logic [15:0] a, input logic [7:0] b, input logic [3:0] k);
        exp_t e;
        longint unsigned bk, q;
        if (b == 8'd0) begin
            e.dat  = 16'hFFFF;
            e.rem  = a;
            e.div0 = 1'b1;
            e.lat  = 0;
        end else begin
            bk     = longint'(b) << k;
            q      = (longint'(a) / bk) << k;
            e.dat  = q[15:0];
            e.rem  = 16'(longint'(a) - q * longint'(b));
            e.div0 = 1'b0;
            e.lat  = 16 - int'(k);
        end
        return e;
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [7:0] b, input logic [3:0] k, input int hold);
        exp_t e, got;
        int   n;
        logic [15:0] d0, r0;
        n = 0;
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_issue", 32'(ready_o), 32'd1);
        dat_in_a = a;
        dat_in_b = b;
        mask     = k;
        valid_i  = 1'b1;
        sb.push_back(model(a, b, k));
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        @(negedge clk);
        n = 0;
        while (!valid_o && n < 40) begin
            dat_in_a = 16'($urandom);
            dat_in_b = 8'($urandom);
            mask     = 4'($urandom);
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        got = sb.pop_front();
        e   = got;
        check("valid_seen", 32'(valid_o), 32'd1);
        check("latency", 32'(n), 32'(e.lat));
        check("dat", 32'(dat_o), 32'(e.dat));
        check("rem", 32'(rem_o), 32'(e.rem));
        check("div0", 32'(div0_o), 32'(e.div0));
        check("ready_in_done", 32'(ready_o), 32'd0);
        $display("op a=%0d b=%0d k=%0d -> dat=%0d rem=%0d div0=%0d lat=%0d", a, b, k, dat_o, rem_o, div0_o, n);
        d0 = dat_o;
        r0 = rem_o;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(valid_o), 32'd1);
            check("hold_ready", 32'(ready_o), 32'd0);
            check("hold_dat", 32'(dat_o), 32'(d0));
            check("hold_rem", 32'(rem_o), 32'(r0));
        end
        ready_i = 1'b1;
        @(negedge clk);
        ready_i = 1'b0;
        check("retire_valid", 32'(valid_o), 32'd0);
        check("retire_ready", 32'(ready_o), 32'd1);
    endtask

    initial begin
        rst      = 1'b1;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        dat_in_a = 16'd0;
        dat_in_b = 8'd0;
        mask     = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_dat", 32'(dat_o), 32'd0);
        check("rst_rem", 32'(rem_o), 32'd0);
        check("rst_div0", 32'(div0_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(ready_o), 32'd1);

        run_op(16'd1000, 8'd7, 4'd0, 0);
        run_op(16'hFFFF, 8'd1, 4'd0, 0);
        run_op(16'hFFFF, 8'd255, 4'd0, 0);
        run_op(16'd1000, 8'd7, 4'd4, 0);
        run_op(16'd1000, 8'd7, 4'd15, 0);
        run_op(16'h1234, 8'd0, 4'd5, 0);
        run_op(16'd50000, 8'd13, 4'd3, 10);
        run_op(16'd255, 8'd255, 4'd0, 2);
        for (int i = 0; i < 6; i++) begin
            run_op(16'($urandom), 8'($urandom_range(1, 255)), 4'($urandom), 0);
        end

        // Reset asserted across the fifth iteration edge of a running divide.
        dat_in_a = 16'd1000;
        dat_in_b = 8'd7;
        mask     = 4'd0;
        valid_i  = 1'b1;
        sb.push_back(model(16'd1000, 8'd7, 4'd0));
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        void'(sb.pop_front());
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_ready", 32'(ready_o), 32'd1);
        check("midrst_dat", 32'(dat_o), 32'd0);
        check("midrst_rem", 32'(rem_o), 32'd0);
        check("midrst_div0", 32'(div0_o), 32'd0);
        $display("reset mid-operation: valid=%0d ready=%0d dat=%0d rem=%0d", valid_o, ready_o, dat_o, rem_o);
        run_op(16'd100, 8'd9, 4'd0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
